// File: rtl/tube_0c_issue_pkg.sv
// Shared definitions for the tube_0c issue/operand stage: default widths and
// the occupancy encoding of the two-entry main/skid buffer.
package tube_0c_issue_pkg;

  localparam int REG_WIDTH_DEF      = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;

  // EMPTY: nothing held. MAIN: only M holds a micro-op. FULL: M and S both hold one.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/tube_fwd_patch.sv
// Combinational operand patch: replaces a register-sourced operand with the
// writeback value when the writeback targets the same nonzero register.
module tube_fwd_patch
  import tube_0c_issue_pkg::*;
#(
  parameter int REG_WIDTH      = REG_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic [REG_WIDTH-1:0]      data,
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic                      rs_en,
  input  logic                      fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  input  logic [REG_WIDTH-1:0]      fwd_data,
  output logic [REG_WIDTH-1:0]      patched
);

  logic hit;

  // Register 0 is hardwired, so a writeback to it never overrides an operand.
  assign hit     = fwd_valid && rs_en && (rs == fwd_rd) && (fwd_rd != '0);
  assign patched = hit ? fwd_data : data;

endmodule

// File: rtl/tube_0c_issue.sv
// Issue/operand stage feeding tube_0c: registers micro-ops through a main entry
// and a skid entry, patching held and incoming operands from the writeback port.
module tube_0c_issue
  import tube_0c_issue_pkg::*;
#(
  parameter int  REG_WIDTH      = REG_WIDTH_DEF,
  parameter int  REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter type T_tube_op      = logic
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_WIDTH-1:0]      in_data1,
  input  logic [REG_WIDTH-1:0]      in_data2,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic                      in_rs1_en,
  input  logic                      in_rs2_en,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  T_tube_op                  in_op,
  input  logic                      fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  input  logic [REG_WIDTH-1:0]      fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_WIDTH-1:0]      out_data1,
  output logic [REG_WIDTH-1:0]      out_data2,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output T_tube_op                  out_op
);

  typedef struct packed {
    logic [REG_WIDTH-1:0]      data1;
    logic [REG_WIDTH-1:0]      data2;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic                      rs1_en;
    logic                      rs2_en;
    logic [REG_ADDR_WIDTH-1:0] rd;
    T_tube_op                  op;
  } entry_t;

  occ_e   state_q, state_d;
  entry_t m_q, m_d, s_q, s_d, in_e;
  entry_t src [3];
  entry_t pat [3];
  logic [REG_WIDTH-1:0] d1p [3];
  logic [REG_WIDTH-1:0] d2p [3];
  logic accept, drain;

  always_comb begin
    in_e.data1  = in_data1;
    in_e.data2  = in_data2;
    in_e.rs1    = in_rs1;
    in_e.rs2    = in_rs2;
    in_e.rs1_en = in_rs1_en;
    in_e.rs2_en = in_rs2_en;
    in_e.rd     = in_rd;
    in_e.op     = in_op;
  end

  // Slot 0 is the incoming micro-op, 1 the main entry, 2 the skid entry.
  assign src[0] = in_e;
  assign src[1] = m_q;
  assign src[2] = s_q;

  for (genvar g = 0; g < 3; g++) begin : g_patch
    tube_fwd_patch #(.REG_WIDTH(REG_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_patch1 (
      .data(src[g].data1), .rs(src[g].rs1), .rs_en(src[g].rs1_en),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .patched(d1p[g])
    );
    tube_fwd_patch #(.REG_WIDTH(REG_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_patch2 (
      .data(src[g].data2), .rs(src[g].rs2), .rs_en(src[g].rs2_en),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .patched(d2p[g])
    );
    always_comb begin
      pat[g]       = src[g];
      pat[g].data1 = d1p[g];
      pat[g].data2 = d2p[g];
    end
  end

  // in_ready depends only on the occupancy flops, so it is free of input paths.
  assign in_ready  = !rst && (state_q != OCC_FULL);
  assign out_valid = (state_q != OCC_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_d = state_q;
    m_d     = pat[1];
    s_d     = pat[2];
    unique case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          m_d     = pat[0];
          state_d = OCC_MAIN;
        end
      end
      OCC_MAIN: begin
        if (drain) begin
          if (accept) m_d = pat[0];
          else        state_d = OCC_EMPTY;
        end else if (accept) begin
          s_d     = pat[0];
          state_d = OCC_FULL;
        end
      end
      OCC_FULL: begin
        if (drain) begin
          m_d     = pat[2];
          state_d = OCC_MAIN;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    if (flush) state_d = OCC_EMPTY;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      state_q <= OCC_EMPTY;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
    end
  end

  // NOTE: the skid payload is deliberately not reset; its validity lives in
  // state_q, and only M needs clearing because it drives the outputs.
  always_ff @(posedge clk) begin
    s_q <= s_d;
  end

  assign out_data1 = m_q.data1;
  assign out_data2 = m_q.data2;
  assign out_rd    = m_q.rd;
  assign out_op    = m_q.op;

endmodule

// File: tb/tb_tube_0c_issue.sv
// Scoreboard bench for tube_0c_issue: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every downstream handshake.
module tb_tube_0c_issue;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        op;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data1 = '0, in_data2 = '0;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_rs1_en = 1'b0, in_rs2_en = 1'b0;
  logic        in_op = 1'b0;
  logic        fwd_valid = 1'b0;
  logic [4:0]  fwd_rd = '0;
  logic [31:0] fwd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data1, out_data2;
  logic [4:0]  out_rd;
  logic        out_op;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   waited;

  always #5 clk = ~clk;

  tube_0c_issue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
    .in_rd(in_rd), .in_op(in_op),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data1(out_data1), .out_data2(out_data2),
    .out_rd(out_rd), .out_op(out_op)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Downstream monitor: one pop per handshake, every field compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("out_data1", out_data1, e.d1);
          check("out_data2", out_data2, e.d2);
          check("out_rd", out_rd, e.rd);
          check("out_op", out_op, e.op);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the micro-op on the input until accepted; returns stall cycles.
  task automatic send(input logic [31:0] d1, input logic [31:0] d2,
                      input logic [4:0] rs1, input logic en1,
                      input logic [4:0] rs2, input logic en2,
                      input logic [4:0] rd, input logic op,
                      input logic [31:0] e1, input logic [31:0] e2,
                      output int stalls);
    exp_t e;
    bit   accepted = 0;
    stalls    = 0;
    in_valid  = 1'b1;
    in_data1  = d1;  in_data2  = d2;
    in_rs1    = rs1; in_rs1_en = en1;
    in_rs2    = rs2; in_rs2_en = en2;
    in_rd     = rd;  in_op     = op;
    while (!accepted && stalls < 20) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        e.d1 = e1; e.d2 = e2; e.rd = rd; e.op = op;
        exp_q.push_back(e);
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) check("send_timeout", accepted, 1'b1);
  endtask

  initial begin
    // Reset
    idle(1);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_out_data", {out_data1, out_data2}, 64'h0);
    check("post_rst_out_rd_op", {out_rd, out_op}, 6'h0);
    @(posedge clk);
    #1;

    // Single op, one-cycle latency
    out_ready = 1'b1;
    send(32'd5, 32'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 32'd5, 32'd7, waited);
    @(negedge clk);
    check("single_out_valid", out_valid, 1'b1);
    check("single_out_data1", out_data1, 32'd5);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("single_out_valid_drop", out_valid, 1'b0);
    idle(1);

    // Back-to-back stream at full rate
    for (int i = 0; i < 8; i++) begin
      send(32'h100 + i, 32'h200 + i, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i + 2), i[0],
           32'h100 + i, 32'h200 + i, waited);
      check("stream_stall", waited, 0);
    end
    idle(3);

    // Backpressure: out_ready low for three cycles
    out_ready = 1'b0;
    send(32'hA0, 32'hA1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 32'hA0, 32'hA1, waited);
    send(32'hB0, 32'hB1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b0, 32'hB0, 32'hB1, waited);
    check("bp_skid_accept_stall", waited, 0);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_out_hold", out_data1, 32'hA0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(32'hC0, 32'hC1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 32'hC0, 32'hC1, waited);
    check("bp_release_stall", waited, 1);
    send(32'hD0, 32'hD1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b0, 32'hD0, 32'hD1, waited);
    idle(4);

    // Forwarding into held M and S; writeback to r0 never patches
    out_ready = 1'b0;
    send(32'h10, 32'h20, 5'd3, 1'b1, 5'd4, 1'b1, 5'd14, 1'b1, 32'hAB, 32'h20, waited);
    send(32'h30, 32'h40, 5'd0, 1'b1, 5'd3, 1'b1, 5'd15, 1'b0, 32'h30, 32'hAB, waited);
    fwd_valid = 1'b1; fwd_rd = 5'd3; fwd_data = 32'hAB;
    @(negedge clk);
    check("fwd_held_before", out_data1, 32'h10);
    @(posedge clk);
    #1 fwd_rd = 5'd0; fwd_data = 32'hEE;
    @(negedge clk);
    check("fwd_held_after", out_data1, 32'hAB);
    @(posedge clk);
    #1 fwd_valid = 1'b0;
    @(negedge clk);
    check("fwd_r0_ignored", out_data2, 32'h20);
    @(posedge clk);
    #1 out_ready = 1'b1;
    idle(4);

    // Immediate kept; forward captured at accept
    fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'h99;
    send(32'h50, 32'h77, 5'd6, 1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 32'h50, 32'h77, waited);
    send(32'h60, 32'h11, 5'd7, 1'b1, 5'd5, 1'b1, 5'd16, 1'b0, 32'h60, 32'h99, waited);
    fwd_valid = 1'b0;
    idle(4);

    // Flush with M and S full and an input pending
    out_ready = 1'b0;
    send(32'hE1, 32'hE2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd17, 1'b0, 32'hE1, 32'hE2, waited);
    send(32'hF1, 32'hF2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd18, 1'b1, 32'hF1, 32'hF2, waited);
    in_valid = 1'b1; in_data1 = 32'hDEAD; in_data2 = 32'hBEEF; in_rd = 5'd19;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Flush while empty with an acceptable input: the input is dropped
    in_valid = 1'b1; in_data1 = 32'hBAD0; in_data2 = 32'hBAD1; in_rd = 5'd20;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_drop_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    send(32'hC1, 32'hC2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 32'hC1, 32'hC2, waited);
    idle(2);

    // Everything pushed must have been seen downstream
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
